ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the single 64 KB BRAM port A between the Z80 CPU and the ESP32 SPI loader.
//  Sequences every access as a 2-cycle grant and buffers one SPI request.
//  Stalls the CPU through wait_n while its access is pending.
//  Bounds CPU starvation under SPI bursts. Sits between the CPU/spi_ram_btn and the dpram.
// PARAMETERS
//  ADDR_BITS  16     RAM address width
//  DATA_BITS  8      RAM data width
//  SPI_SPACE  8'h00  spi_addr[31:24] value that selects RAM
//  MAX_STALL  4      max consecutive SPI grants while a CPU access waits (1..15)
// PORTS
//  clk        in   1          system clock (clk_cpu domain)
//  reset_n    in   1          asynchronous active-low reset
//  cpu_req    in   1          CPU memory access active (level, held for whole bus cycle)
//  cpu_we     in   1          1 = write; sampled with cpu_req rising edge
//  cpu_addr   in   ADDR_BITS  CPU address, sampled with cpu_req rising edge
//  cpu_din    in   DATA_BITS  CPU write data, sampled with cpu_req rising edge
//  cpu_dout   out  DATA_BITS  last CPU read data (held until next CPU read completes)
//  cpu_wait_n out  1          0 = stall CPU (to tv80 wait_n)
//  spi_hold   in   1          1 = CPU grants blocked entirely (loader mode)
//  spi_wr     in   1          1-cycle SPI write strobe
//  spi_rd     in   1          1-cycle SPI read strobe
//  spi_addr   in   32         SPI address; [ADDR_BITS-1:0] = RAM address
//  spi_din    in   DATA_BITS  SPI write data
//  spi_dout   out  DATA_BITS  last SPI read data
//  spi_busy   out  1          SPI request pending or in service
//  spi_ovf    out  1          sticky: SPI strobe dropped because holding register full
//  ram_we     out  1          BRAM write enable
//  ram_addr   out  ADDR_BITS  BRAM address
//  ram_din    out  DATA_BITS  BRAM write data
//  ram_dout   in   DATA_BITS  BRAM read data (1-cycle registered latency)
// BEHAVIOUR
//  Reset values:
//  - all outputs 0, except cpu_wait_n = 1.
//  - FSM = IDLE, pending flags clear, stall counter 0.
//  CPU request capture:
//  - Rising edge of cpu_req (registered prev) latches we/addr/din and sets cpu_pend.
//  - No new CPU request until cpu_req falls and rises again.
//  SPI request capture:
//  - spi_wr|spi_rd with spi_addr[31:24]==SPI_SPACE latches into 1-entry holding reg, sets spi_pend.
//  - Other spaces are ignored entirely.
//  - A strobe arriving while spi_pend=1 is dropped and sets spi_ovf (cleared only by reset).
//  - spi_wr and spi_rd together are treated as a write.
//  FSM states: IDLE, CPU_A, CPU_D, SPI_A, SPI_D.
//  - *_A: ram_addr/ram_din/ram_we valid for exactly this cycle; ram_we=1 only for writes.
//  - *_D: ram_dout captured at end of cycle into cpu_dout/spi_dout (reads only); pend flag cleared.
//  Arbitration at end of IDLE/CPU_D/SPI_D (back-to-back allowed, 1 access per 2 cycles):
//  - SPI wins if spi_pend && (!cpu_pend || spi_hold || stall_cnt < MAX_STALL).
//  - Otherwise CPU wins if cpu_pend && !spi_hold; else IDLE.
//  - stall_cnt increments on each SPI grant while cpu_pend=1; resets to 0 on each CPU grant
//    or when cpu_pend=0; saturates at MAX_STALL.
//  - A request latched in the same cycle as arbitration is eligible in that arbitration.
//  cpu_wait_n (registered):
//  - Falls at the edge that sets cpu_pend.
//  - Rises at the end of CPU_D, together with the cpu_dout update.
//  - Uncontended read: edge seen at cycle T, CPU_A at T+1, CPU_D at T+2; cpu_dout/wait_n valid T+3.
//  spi_busy = spi_pend | (state in SPI_A/SPI_D).
//  Async reset mid-access aborts it immediately.
//  - ram_we deasserts with no partial write beyond the current cycle.
//  - Pending requests are discarded.
// TESTING
//  1. Reset check: hold reset_n=0 -> cpu_wait_n=1, ram_we=0, spi_busy=0, spi_ovf=0.
//     Release -> IDLE.
//  2. CPU read, uncontended: RAM[0x1234]=0xA5, cpu_req rises at T
//     -> ram_addr=0x1234 at T+1, cpu_wait_n=0 T+1..T+2, cpu_dout=0xA5 and wait_n=1 at T+3.
//  3. SPI then CPU: spi_wr to 0x00001000 data 0x5C, then CPU read 0x1000
//     -> ram_we=1 for exactly one cycle, cpu_dout=0x5C.
//  4. Collision: spi_rd and cpu_req edge in same cycle -> SPI grant first,
//     CPU wait_n low 2 extra cycles, both data correct.
//  5. Starvation: MAX_STALL=2, CPU pending, SPI strobe every 2 cycles
//     -> grant order SPI,SPI,CPU,SPI,SPI,CPU.
//     With spi_hold=1 -> CPU never granted, wait_n stays 0.
//  6. Overflow/space/reset: second spi_wr while pending -> spi_ovf=1, dropped write not in RAM.
//     spi_wr to 0xFF000000 -> no ram_we.
//     reset_n low during CPU_A -> ram_we=0 at once, wait_n=1.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Arbitrates the single BRAM port A between the Z80 bus and the SPI loader.
// Each access takes two cycles (address, data); one SPI request is buffered.
module ram_port_arbiter #(
  parameter int unsigned ADDR_BITS = 16,
  parameter int unsigned DATA_BITS = 8,
  parameter logic [7:0]  SPI_SPACE = 8'h00,
  parameter int unsigned MAX_STALL = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic [DATA_BITS-1:0] cpu_din,
  output logic [DATA_BITS-1:0] cpu_dout,
  output logic                 cpu_wait_n,
  input  logic                 spi_hold,
  input  logic                 spi_wr,
  input  logic                 spi_rd,
  input  logic [31:0]          spi_addr,
  input  logic [DATA_BITS-1:0] spi_din,
  output logic [DATA_BITS-1:0] spi_dout,
  output logic                 spi_busy,
  output logic                 spi_ovf,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [DATA_BITS-1:0] ram_din,
  input  logic [DATA_BITS-1:0] ram_dout
);

  localparam int unsigned CNT_BITS = 4;
  localparam logic [CNT_BITS-1:0] STALL_LIMIT = CNT_BITS'(MAX_STALL);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CPU_A = 3'd1,
    CPU_D = 3'd2,
    SPI_A = 3'd3,
    SPI_D = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  // Captured CPU request
  logic                 cpu_req_q;
  logic                 cpu_pend;
  logic                 cpu_we_q;
  logic [ADDR_BITS-1:0] cpu_addr_q;
  logic [DATA_BITS-1:0] cpu_din_q;

  // SPI holding register
  logic                 spi_pend;
  logic                 spi_we_q;
  logic [ADDR_BITS-1:0] spi_addr_q;
  logic [DATA_BITS-1:0] spi_din_q;

  logic [CNT_BITS-1:0]  stall_cnt;

  logic                 cpu_rise;
  logic                 spi_strobe;
  logic                 spi_full;
  logic                 spi_cap;
  logic                 spi_drop;
  logic                 cpu_avail;
  logic                 spi_avail;
  logic                 arb_point;
  logic                 grant_spi;
  logic                 grant_cpu;

  logic                 cpu_sel_we;
  logic [ADDR_BITS-1:0] cpu_sel_addr;
  logic [DATA_BITS-1:0] cpu_sel_din;
  logic                 spi_sel_we;
  logic [ADDR_BITS-1:0] spi_sel_addr;
  logic [DATA_BITS-1:0] spi_sel_din;

  if (ADDR_BITS < 24) begin : g_spi_addr_mid
    logic unused_spi_addr;
    assign unused_spi_addr = ^spi_addr[23:ADDR_BITS];
  end

  // Request detection; the holding register frees up at the end of SPI_D,
  // so a strobe arriving in that cycle is accepted rather than dropped.
  assign cpu_rise   = cpu_req && !cpu_req_q && !cpu_pend;
  assign spi_strobe = (spi_wr || spi_rd) && (spi_addr[31:24] == SPI_SPACE);
  assign spi_full   = spi_pend && (state != SPI_D);
  assign spi_cap    = spi_strobe && !spi_full;
  assign spi_drop   = spi_strobe && spi_full;

  // Requests visible to this cycle's arbitration, including same-cycle captures
  assign cpu_avail  = cpu_rise || (cpu_pend && (state != CPU_D));
  assign spi_avail  = spi_cap  || (spi_pend && (state != SPI_D));
  assign arb_point  = (state == IDLE) || (state == CPU_D) || (state == SPI_D);

  assign grant_spi  = arb_point && spi_avail &&
                      (!cpu_avail || spi_hold || (stall_cnt < STALL_LIMIT));
  assign grant_cpu  = arb_point && !grant_spi && cpu_avail && !spi_hold;

  assign cpu_sel_we   = cpu_rise ? cpu_we   : cpu_we_q;
  assign cpu_sel_addr = cpu_rise ? cpu_addr : cpu_addr_q;
  assign cpu_sel_din  = cpu_rise ? cpu_din  : cpu_din_q;
  assign spi_sel_we   = spi_cap  ? spi_wr                    : spi_we_q;
  assign spi_sel_addr = spi_cap  ? spi_addr[ADDR_BITS-1:0]   : spi_addr_q;
  assign spi_sel_din  = spi_cap  ? spi_din                   : spi_din_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, CPU_D, SPI_D: begin
        if (grant_spi) begin
          state_nxt = SPI_A;
        end else if (grant_cpu) begin
          state_nxt = CPU_A;
        end else begin
          state_nxt = IDLE;
        end
      end
      CPU_A:   state_nxt = CPU_D;
      SPI_A:   state_nxt = SPI_D;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_req_q  <= 1'b0;
      cpu_pend   <= 1'b0;
      cpu_we_q   <= 1'b0;
      cpu_addr_q <= '0;
      cpu_din_q  <= '0;
    end else begin
      cpu_req_q <= cpu_req;
      if (cpu_rise) begin
        cpu_pend   <= 1'b1;
        cpu_we_q   <= cpu_we;
        cpu_addr_q <= cpu_addr;
        cpu_din_q  <= cpu_din;
      end else if (state == CPU_D) begin
        cpu_pend <= 1'b0;
      end
    end
  end

  // A simultaneous write+read strobe is taken as a write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spi_pend   <= 1'b0;
      spi_we_q   <= 1'b0;
      spi_addr_q <= '0;
      spi_din_q  <= '0;
      spi_ovf    <= 1'b0;
    end else begin
      if (spi_cap) begin
        spi_pend   <= 1'b1;
        spi_we_q   <= spi_wr;
        spi_addr_q <= spi_addr[ADDR_BITS-1:0];
        spi_din_q  <= spi_din;
      end else if (state == SPI_D) begin
        spi_pend <= 1'b0;
      end
      if (spi_drop) begin
        spi_ovf <= 1'b1;
      end
    end
  end

  // Consecutive SPI grants while the CPU waits; forces a CPU slot at the limit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (grant_cpu || !cpu_avail) begin
      stall_cnt <= '0;
    end else if (grant_spi && (stall_cnt < STALL_LIMIT)) begin
      stall_cnt <= stall_cnt + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else if (grant_spi) begin
      ram_we   <= spi_sel_we;
      ram_addr <= spi_sel_addr;
      ram_din  <= spi_sel_din;
    end else if (grant_cpu) begin
      ram_we   <= cpu_sel_we;
      ram_addr <= cpu_sel_addr;
      ram_din  <= cpu_sel_din;
    end else begin
      ram_we   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_dout   <= '0;
      cpu_wait_n <= 1'b1;
      spi_dout   <= '0;
      spi_busy   <= 1'b0;
    end else begin
      if (cpu_rise) begin
        cpu_wait_n <= 1'b0;
      end else if (state == CPU_D) begin
        cpu_wait_n <= 1'b1;
      end
      if ((state == CPU_D) && !cpu_we_q) begin
        cpu_dout <= ram_dout;
      end
      if ((state == SPI_D) && !spi_we_q) begin
        spi_dout <= ram_dout;
      end
      spi_busy <= spi_avail || (state_nxt == SPI_A) || (state_nxt == SPI_D);
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a behavioural BRAM, a vector table of single
// accesses with read-data scoreboards, and scripted multi-cycle sequences.
module tb_ram_port_arbiter;

  logic        clk;
  logic        reset_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_wait_n;
  logic        spi_hold;
  logic        spi_wr;
  logic        spi_rd;
  logic [31:0] spi_addr;
  logic [7:0]  spi_din;
  logic [7:0]  spi_dout;
  logic        spi_busy;
  logic        spi_ovf;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;

  ram_port_arbiter #(
    .ADDR_BITS(16),
    .DATA_BITS(8),
    .SPI_SPACE(8'h00),
    .MAX_STALL(2)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_wait_n(cpu_wait_n),
    .spi_hold(spi_hold), .spi_wr(spi_wr), .spi_rd(spi_rd), .spi_addr(spi_addr),
    .spi_din(spi_din), .spi_dout(spi_dout), .spi_busy(spi_busy), .spi_ovf(spi_ovf),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous BRAM, read-first, one cycle of read latency
  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  typedef struct {
    logic        spi;
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [7:0]  din;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs [11];

  int n_vec;
  int n_err;
  logic [7:0]  cpu_q   [$];
  logic [7:0]  spi_q   [$];
  logic [15:0] grant_q [$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cpu_access(input logic we, input logic [15:0] addr, input logic [7:0] din,
                            input logic [7:0] exp);
    int cnt;
    logic [7:0] e;
    cpu_we = we; cpu_addr = addr; cpu_din = din; cpu_req = 1'b1;
    if (!we) cpu_q.push_back(exp);
    tick;
    cnt = 0;
    while (!cpu_wait_n && cnt < 32) begin
      tick;
      cnt++;
    end
    check("cpu_done", 32'(cpu_wait_n), 32'd1);
    if (!we) begin
      e = cpu_q.pop_front();
      check("cpu_rd_data", 32'(cpu_dout), 32'(e));
    end
    cpu_req = 1'b0;
    tick;
  endtask

  task automatic spi_access(input logic wr, input logic rd, input logic [31:0] addr,
                            input logic [7:0] din, input logic [7:0] exp);
    int cnt;
    logic [7:0] e;
    spi_wr = wr; spi_rd = rd; spi_addr = addr; spi_din = din;
    if (rd && !wr) spi_q.push_back(exp);
    tick;
    spi_wr = 1'b0; spi_rd = 1'b0;
    cnt = 0;
    while (spi_busy && cnt < 32) begin
      tick;
      cnt++;
    end
    check("spi_done", 32'(spi_busy), 32'd0);
    if (rd && !wr) begin
      e = spi_q.pop_front();
      check("spi_rd_data", 32'(spi_dout), 32'(e));
    end
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] last_addr;
    logic [15:0] g;
    int          hi_cnt;
    int          we_cnt;
    int          cnt;

    n_vec = 0; n_err = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_din = '0;
    spi_hold = 0; spi_wr = 0; spi_rd = 0; spi_addr = '0; spi_din = '0;

    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0000_1234, 8'hA5, 8'h00};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0000_FFFF, 8'h77, 8'h00};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h0000_1234, 8'h00, 8'hA5};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0000_2000, 8'h3C, 8'h00};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'h0000_2000, 8'h00, 8'h3C};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0040, 8'h99, 8'h00};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0040, 8'h00, 8'h99};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'h0000_FFFF, 8'h00, 8'h77};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0501, 8'hEE, 8'h00};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0700, 8'h55, 8'h00};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h0000_FFFF, 8'h00, 8'h77};

    // Reset values
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    tick; tick;
    check("rst_wait_n", 32'(cpu_wait_n), 32'd1);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_spi_busy", 32'(spi_busy), 32'd0);
    check("rst_spi_ovf", 32'(spi_ovf), 32'd0);
    check("rst_cpu_dout", 32'(cpu_dout), 32'd0);
    reset_n = 1'b1;
    tick;

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].spi) spi_access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].din, vecs[i].exp);
      else             cpu_access(vecs[i].wr, vecs[i].addr[15:0], vecs[i].din, vecs[i].exp);
    end

    // Uncontended CPU read latency (cpu_dout currently 0x77)
    cpu_we = 1'b0; cpu_addr = 16'h1234; cpu_req = 1'b1;
    tick;
    check("lat_addr_t1", 32'(ram_addr), 32'h1234);
    check("lat_wait_t1", 32'(cpu_wait_n), 32'd0);
    tick;
    check("lat_wait_t2", 32'(cpu_wait_n), 32'd0);
    check("lat_dout_t2", 32'(cpu_dout), 32'h77);
    tick;
    check("lat_wait_t3", 32'(cpu_wait_n), 32'd1);
    check("lat_dout_t3", 32'(cpu_dout), 32'hA5);
    cpu_req = 1'b0;
    tick;

    // SPI write pulses ram_we for exactly one cycle, then CPU reads it back
    spi_wr = 1'b1; spi_addr = 32'h0000_1000; spi_din = 8'h5C;
    tick;
    spi_wr = 1'b0;
    check("wr_we_t1", 32'(ram_we), 32'd1);
    check("wr_addr_t1", 32'(ram_addr), 32'h1000);
    check("wr_din_t1", 32'(ram_din), 32'h5C);
    tick;
    check("wr_we_t2", 32'(ram_we), 32'd0);
    tick; tick;
    cpu_access(1'b0, 16'h1000, 8'h00, 8'h5C);

    // Collision: SPI read and CPU read in the same cycle, SPI served first
    spi_rd = 1'b1; spi_addr = 32'h0000_1234;
    cpu_we = 1'b0; cpu_addr = 16'h2000; cpu_req = 1'b1;
    tick;
    spi_rd = 1'b0;
    check("col_first_addr", 32'(ram_addr), 32'h1234);
    tick; tick;
    check("col_second_addr", 32'(ram_addr), 32'h2000);
    check("col_spi_dout", 32'(spi_dout), 32'hA5);
    tick;
    check("col_wait_t4", 32'(cpu_wait_n), 32'd0);
    tick;
    check("col_wait_t5", 32'(cpu_wait_n), 32'd1);
    check("col_cpu_dout", 32'(cpu_dout), 32'h3C);
    cpu_req = 1'b0;
    tick;

    // Starvation bound with MAX_STALL=2: two SPI grants, then the CPU, twice
    grant_q.push_back(16'h0100); grant_q.push_back(16'h0101); grant_q.push_back(16'h0200);
    grant_q.push_back(16'h0102); grant_q.push_back(16'h0103); grant_q.push_back(16'h0201);
    last_addr = ram_addr;
    for (int c = 0; c < 17; c++) begin
      cpu_we   = 1'b0;
      cpu_req  = (c != 7);
      cpu_addr = (c < 8) ? 16'h0200 : 16'h0201;
      spi_wr   = (c == 0) || (c == 2) || (c == 8) || (c == 10);
      spi_addr = 32'h0000_0100 + 32'((c >= 8) ? 2 : 0) + 32'(((c % 8) == 2) ? 1 : 0);
      spi_din  = 8'(c);
      tick;
      if (ram_addr != last_addr) begin
        if (grant_q.size() == 0) begin
          check("stv_extra_grant", 32'(ram_addr), 32'(last_addr));
        end else begin
          g = grant_q.pop_front();
          check("stv_grant_order", 32'(ram_addr), 32'(g));
        end
        last_addr = ram_addr;
      end
    end
    spi_wr = 1'b0; cpu_req = 1'b0;
    check("stv_grants_left", 32'(grant_q.size()), 32'd0);
    check("stv_no_ovf", 32'(spi_ovf), 32'd0);
    check("stv_wait_done", 32'(cpu_wait_n), 32'd1);
    tick;

    // spi_hold blocks the CPU but still serves SPI
    spi_hold = 1'b1;
    cpu_we = 1'b0; cpu_addr = 16'h0300; cpu_req = 1'b1;
    hi_cnt = 0; we_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      spi_wr = (i == 3); spi_addr = 32'h0000_0310; spi_din = 8'h5A;
      tick;
      if (cpu_wait_n) hi_cnt++;
      if (ram_we) we_cnt++;
    end
    spi_wr = 1'b0;
    check("hold_wait_high_cycles", 32'(hi_cnt), 32'd0);
    check("hold_spi_writes", 32'(we_cnt), 32'd1);
    spi_hold = 1'b0;
    cnt = 0;
    while (!cpu_wait_n && cnt < 32) begin
      tick;
      cnt++;
    end
    check("hold_release_done", 32'(cpu_wait_n), 32'd1);
    cpu_req = 1'b0;
    tick;

    // Overflow: second strobe while the first is still pending is dropped
    check("ovf_before", 32'(spi_ovf), 32'd0);
    spi_wr = 1'b1; spi_addr = 32'h0000_0500; spi_din = 8'h11;
    tick;
    spi_addr = 32'h0000_0501; spi_din = 8'h22;
    tick;
    spi_wr = 1'b0;
    check("ovf_set", 32'(spi_ovf), 32'd1);
    tick; tick; tick;
    spi_access(1'b0, 1'b1, 32'h0000_0501, 8'h00, 8'hEE);
    spi_access(1'b0, 1'b1, 32'h0000_0500, 8'h00, 8'h11);

    // Foreign address space is ignored
    spi_wr = 1'b1; spi_addr = 32'hFF00_0600; spi_din = 8'h33;
    we_cnt = 0;
    tick;
    spi_wr = 1'b0;
    check("space_busy", 32'(spi_busy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (ram_we) we_cnt++;
      tick;
    end
    check("space_no_we", 32'(we_cnt), 32'd0);

    // Reset during CPU_A of a write aborts it
    cpu_we = 1'b1; cpu_addr = 16'h0700; cpu_din = 8'h44; cpu_req = 1'b1;
    tick;
    check("rstmid_we_before", 32'(ram_we), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rstmid_we", 32'(ram_we), 32'd0);
    check("rstmid_wait_n", 32'(cpu_wait_n), 32'd1);
    check("rstmid_ovf", 32'(spi_ovf), 32'd0);
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick; tick;
    reset_n = 1'b1;
    tick;
    check("rstmid_busy", 32'(spi_busy), 32'd0);
    spi_access(1'b0, 1'b1, 32'h0000_0700, 8'h00, 8'h55);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
